// File: rtl/fma16_vec_player.sv
// fma16_vec_player: plays vectors from a synchronous vector memory into the
// combinational fma16 datapath and checks each result against its expected value.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, num_vec      run request and number of vectors to play
//   mem_en, mem_addr    vector-memory read port (1-cycle read latency)
//   mem_rdata           76-bit vector {x, y, z, ctrl, expected, flags}
//   x, y, z, mul, add,  registered fma16 operands and controls
//   negp, negz,
//   roundmode
//   result              fma16 output, combinational from the operands
//   busy, done, pass    run status
//   errors, vec_count   saturating mismatch count and checked-vector count
//   err_pulse           one-cycle pulse per mismatch
//   first_err_*         capture of the first failing vector
module fma16_vec_player #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] num_vec,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [75:0]       mem_rdata,
   output logic [15:0]       x,
   output logic [15:0]       y,
   output logic [15:0]       z,
   output logic              mul,
   output logic              add,
   output logic              negp,
   output logic              negz,
   output logic [1:0]        roundmode,
   input  logic [15:0]       result,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [31:0]       errors,
   output logic [ADDR_W:0]   vec_count,
   output logic              err_pulse,
   output logic              first_err_valid,
   output logic [ADDR_W-1:0] first_err_idx,
   output logic [15:0]       first_err_result,
   output logic [15:0]       first_err_expected
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_APPLY = 3'd2;
   localparam logic [2:0] S_CHECK = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_num;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_x;
   logic [15:0]       r_y;
   logic [15:0]       r_z;
   logic [5:0]        r_ctrl;
   logic [15:0]       r_exp;
   logic [31:0]       r_errors;
   logic [ADDR_W:0]   r_vcnt;
   logic              r_err_pulse;
   logic              r_done;
   logic              r_fev;
   logic [ADDR_W-1:0] r_fidx;
   logic [15:0]       r_fres;
   logic [15:0]       r_fexp;

   logic              w_mis;
   logic [ADDR_W-1:0] w_idx_nxt;
   logic              w_last;
   logic              w_unused;

   assign w_mis     = (result != r_exp);
   assign w_idx_nxt = r_idx + 1;
   assign w_last    = (w_idx_nxt == r_num);

   // ctrl[7:6] and the flag nibble are carried in the vector but never used.
   assign w_unused = ^{mem_rdata[27:26], mem_rdata[3:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_num       <= '0;
         r_idx       <= '0;
         r_addr      <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_z         <= '0;
         r_ctrl      <= '0;
         r_exp       <= '0;
         r_errors    <= '0;
         r_vcnt      <= '0;
         r_err_pulse <= 1'b0;
         r_done      <= 1'b0;
         r_fev       <= 1'b0;
         r_fidx      <= '0;
         r_fres      <= '0;
         r_fexp      <= '0;
      end else begin
         r_err_pulse <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_num    <= num_vec;
                  r_idx    <= '0;
                  r_errors <= '0;
                  r_vcnt   <= '0;
                  r_fev    <= 1'b0;
                  r_fidx   <= '0;
                  r_fres   <= '0;
                  r_fexp   <= '0;
                  if (num_vec == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_FETCH;
                     r_done  <= 1'b0;
                     r_addr  <= '0;
                  end
               end
            end
            S_FETCH: begin
               r_state <= S_APPLY;
            end
            S_APPLY: begin
               r_x     <= mem_rdata[75:60];
               r_y     <= mem_rdata[59:44];
               r_z     <= mem_rdata[43:28];
               r_ctrl  <= mem_rdata[25:20];
               r_exp   <= mem_rdata[19:4];
               r_state <= S_CHECK;
            end
            S_CHECK: begin
               if (w_mis) begin
                  if (r_errors != '1) begin
                     r_errors <= r_errors + 1;
                  end
                  r_err_pulse <= 1'b1;
                  if (!r_fev) begin
                     r_fev  <= 1'b1;
                     r_fidx <= r_idx;
                     r_fres <= result;
                     r_fexp <= r_exp;
                  end
               end
               r_vcnt <= r_vcnt + 1;
               r_idx  <= w_idx_nxt;
               if (w_last) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= S_FETCH;
                  r_addr  <= w_idx_nxt;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_en    = (r_state == S_FETCH);
   assign mem_addr  = r_addr;
   assign x         = r_x;
   assign y         = r_y;
   assign z         = r_z;
   assign roundmode = r_ctrl[5:4];
   assign mul       = r_ctrl[3];
   assign add       = r_ctrl[2];
   assign negp      = r_ctrl[1];
   assign negz      = r_ctrl[0];
   assign busy      = (r_state == S_FETCH) ||
                      (r_state == S_APPLY) ||
                      (r_state == S_CHECK);
   assign done      = r_done;
   assign pass      = r_done && (r_errors == '0);
   assign errors    = r_errors;
   assign vec_count = r_vcnt;
   assign err_pulse = r_err_pulse;

   assign first_err_valid    = r_fev;
   assign first_err_idx      = r_fidx;
   assign first_err_result   = r_fres;
   assign first_err_expected = r_fexp;

endmodule

// File: tb/tb_fma16_vec_player.sv
// tb_fma16_vec_player: randomized scoreboard bench for fma16_vec_player with a
// vector-memory model and a deterministic fma16 stand-in driving result.
module tb_fma16_vec_player;

   localparam int AW = 14;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] num_vec;
   logic          mem_en;
   logic [AW-1:0] mem_addr;
   logic [75:0]   mem_rdata;
   logic [15:0]   x, y, z;
   logic          mul, add, negp, negz;
   logic [1:0]    roundmode;
   logic [15:0]   result;
   logic          busy, done, pass;
   logic [31:0]   errors;
   logic [AW:0]   vec_count;
   logic          err_pulse;
   logic          first_err_valid;
   logic [AW-1:0] first_err_idx;
   logic [15:0]   first_err_result;
   logic [15:0]   first_err_expected;

   fma16_vec_player #(.ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .num_vec(num_vec),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .x(x), .y(y), .z(z), .mul(mul), .add(add), .negp(negp),
      .negz(negz), .roundmode(roundmode), .result(result),
      .busy(busy), .done(done), .pass(pass), .errors(errors),
      .vec_count(vec_count), .err_pulse(err_pulse),
      .first_err_valid(first_err_valid),
      .first_err_idx(first_err_idx),
      .first_err_result(first_err_result),
      .first_err_expected(first_err_expected)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errs   = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Vector memory: synchronous read, one cycle latency.
   logic [75:0] mem [0:63];
   always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr[5:0]];

   // fma16 stand-in: 1.0*y is exact (with optional product negation),
   // anything else is a deterministic scramble of all operands and controls.
   function automatic logic [15:0] fake(logic [15:0] a, logic [15:0] b,
                                        logic [15:0] c, logic [5:0] ct);
      if (a == 16'h3C00 && c == 16'h0000 && ct[3] && !ct[2])
         return ct[1] ? (b ^ 16'h8000) : b;
      return (a ^ {b[7:0], b[15:8]}) + (c ^ 16'h5A5A) + {10'd0, ct};
   endfunction

   assign result = fake(x, y, z, {roundmode, mul, add, negp, negz});

   function automatic logic [75:0] mkvec(logic [15:0] a, logic [15:0] b,
                                         logic [15:0] c, logic [7:0] ct,
                                         logic [15:0] e);
      logic [3:0] fl;
      fl = 4'($urandom);
      return {a, b, c, ct, e, fl};
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   typedef struct {
      logic [AW-1:0] addr;
      logic [15:0]   vx, vy, vz;
      logic [5:0]    c;
      logic          mis;
   } vexp_t;

   typedef struct {
      int            nerr;
      int            cnt;
      logic          fev;
      logic [AW-1:0] fidx;
      logic [15:0]   fres, fexp;
      int            npulse;
      int            dcyc;
   } sexp_t;

   vexp_t vq[$];
   sexp_t sq[$];

   // Monitor: per-vector fetch/operand/pulse checks and per-run summary.
   vexp_t cur;
   sexp_t sm;
   int    ph = 0;
   int    npulse = 0;
   logic  prev_done = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         ph = 0;
         npulse = 0;
         prev_done = 1'b0;
      end else begin
         case (ph)
            3: begin
               chk("err_pulse", err_pulse, cur.mis);
               if (err_pulse) npulse++;
               ph = 0;
            end
            2: begin
               chk("op_x", x, cur.vx);
               chk("op_y", y, cur.vy);
               chk("op_z", z, cur.vz);
               chk("ctrl", {roundmode, mul, add, negp, negz}, cur.c);
               chk("busy_check", busy, 1);
               ph = 3;
            end
            1: ph = 2;
            default: begin
               if (err_pulse) begin
                  checks++; errs++;
                  $display("FAIL stray_err_pulse actual=1 required=0");
               end
            end
         endcase
         if (mem_en) begin
            if (vq.size() == 0 || ph != 0) begin
               checks++; errs++;
               $display("FAIL stray_fetch addr actual=%0h required=none",
                        mem_addr);
            end else begin
               cur = vq.pop_front();
               chk("fetch_addr", mem_addr, cur.addr);
               ph = 1;
            end
         end
         if (done && !prev_done) begin
            if (sq.size() == 0) begin
               checks++; errs++;
               $display("FAIL stray_done actual=1 required=0");
            end else begin
               sm = sq.pop_front();
               chk("done_cycle", cyc, sm.dcyc);
               chk("errors", errors, sm.nerr);
               chk("vec_count", vec_count, sm.cnt);
               chk("pass", pass, sm.nerr == 0);
               chk("busy_done", busy, 0);
               chk("first_err_valid", first_err_valid, sm.fev);
               if (sm.fev) begin
                  chk("first_err_idx", first_err_idx, sm.fidx);
                  chk("first_err_result", first_err_result, sm.fres);
                  chk("first_err_expected", first_err_expected, sm.fexp);
               end
               chk("pulse_count", npulse, sm.npulse);
            end
            npulse = 0;
         end
         prev_done = done;
      end
   end

   // Reference: expectations derived from the memory contents only.
   task automatic issue(int n, bit mid);
      sexp_t s;
      vexp_t e;
      logic [75:0] v;
      logic [15:0] r;
      s.nerr = 0; s.cnt = n; s.fev = 1'b0; s.fidx = '0;
      s.fres = '0; s.fexp = '0; s.npulse = 0; s.dcyc = 0;
      for (int i = 0; i < n; i++) begin
         v = mem[i];
         r = fake(v[75:60], v[59:44], v[43:28], v[25:20]);
         e.addr = AW'(i);
         e.vx = v[75:60]; e.vy = v[59:44]; e.vz = v[43:28];
         e.c = v[25:20];
         e.mis = (r != v[19:4]);
         vq.push_back(e);
         if (e.mis) begin
            s.nerr++;
            s.npulse++;
            if (!s.fev) begin
               s.fev = 1'b1; s.fidx = AW'(i);
               s.fres = r; s.fexp = v[19:4];
            end
         end
      end
      @(posedge clk); #1;
      start = 1'b1;
      num_vec = AW'(n);
      s.dcyc = cyc + 1 + 3 * n;
      sq.push_back(s);
      @(posedge clk); #1;
      start = 1'b0;
      num_vec = AW'($urandom);
      if (mid) begin
         repeat (7) @(posedge clk);
         #1 start = 1'b1;
         num_vec = AW'(3);
         @(posedge clk); #1 start = 1'b0;
      end
   endtask

   task automatic finish_run(int n);
      for (int k = 0; k < 3 * n + 20 && sq.size() != 0; k++)
         @(posedge clk);
      checks++;
      if (sq.size() != 0) begin
         errs++;
         $display("FAIL run_timeout actual=pending required=done");
         sq.delete();
         vq.delete();
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic run(int n, bit mid);
      issue(n, mid);
      finish_run(n);
   endtask

   task automatic rand_vecs(int n, int fail_pct);
      logic [15:0] a, b, c, r, e;
      logic [7:0]  ct;
      for (int i = 0; i < n; i++) begin
         a = ($urandom_range(3) == 0) ? 16'h3C00 : 16'($urandom);
         b = 16'($urandom);
         c = ($urandom_range(1) == 0) ? 16'h0000 : 16'($urandom);
         ct = 8'($urandom);
         r = fake(a, b, c, ct[5:0]);
         e = ($urandom_range(99) < fail_pct) ?
             (r ^ (16'h1 << $urandom_range(15))) : r;
         mem[i] = mkvec(a, b, c, ct, e);
      end
   endtask

   task automatic reset_chk(string tag);
      chk({tag, "_ops"}, {x, y, z}, 0);
      chk({tag, "_ctl"}, {mul, add, negp, negz, roundmode}, 0);
      chk({tag, "_mem"}, {mem_en, mem_addr}, 0);
      chk({tag, "_stat"}, {busy, done, pass, err_pulse, first_err_valid}, 0);
      chk({tag, "_cnt"}, {errors, vec_count}, 0);
      chk({tag, "_ferr"},
          {first_err_idx, first_err_result, first_err_expected}, 0);
   endtask

   initial begin
      bit found;
      reset = 1'b1;
      start = 1'b1;
      num_vec = AW'(3);
      for (int i = 0; i < 64; i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_chk("por");
      @(posedge clk); #1;
      start = 1'b0;
      reset = 1'b0;

      run(0, 1'b0);

      mem[0] = 76'h3C00_4000_0000_08_4000_0;
      run(1, 1'b0);
      chk("single_mul_add", {mul, add}, 2'b10);

      rand_vecs(2, 0);
      mem[2] = mkvec(16'h3C00, 16'h4201, 16'h0000, 8'h08, 16'h4200);
      mem[3] = mkvec(16'h3C00, 16'h4000, 16'h0000, 8'h08, 16'h3C00);
      run(4, 1'b0);
      chk("mis_errors", errors, 2);
      chk("mis_fidx", first_err_idx, 2);
      chk("mis_fres", first_err_result, 16'h4201);
      chk("mis_fexp", first_err_expected, 16'h4200);
      chk("mis_pass", pass, 0);

      mem[0] = mkvec(16'h1234, 16'h5678, 16'h9ABC, 8'h3F, 16'h0000);
      mem[1] = mkvec(16'h3C00, 16'h4400, 16'h0000, 8'h15, 16'h4400);
      run(2, 1'b0);
      chk("ctrl_last", {roundmode, mul, add, negp, negz}, 6'h15);

      rand_vecs(20, 40);
      run(20, 1'b1);
      rand_vecs(10, 0);
      run(10, 1'b0);
      chk("restart_pass", pass, 1);

      rand_vecs(8, 30);
      issue(8, 1'b0);
      found = 1'b0;
      for (int k = 0; k < 60 && !found; k++) begin
         @(negedge clk);
         if (mem_en && mem_addr == AW'(5)) found = 1'b1;
      end
      chk("reach_vec5", found, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      vq.delete();
      sq.delete();
      @(posedge clk);
      @(negedge clk);
      reset_chk("midrst");
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_idle", {busy, done, mem_en}, 0);

      rand_vecs(6, 50);
      run(6, 1'b0);

      chk("vq_drained", vq.size(), 0);
      chk("sq_drained", sq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errs);
      $finish;
   end

endmodule
